// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer state encoding and bit-time default.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_END,
    ST_GUARD
  } tx_state_e;

  localparam int CLK_FRE_MHZ = 50;
  localparam int BAUD_RATE   = 9600;
  localparam int BIT_CYCLES  = CLK_FRE_MHZ * 1_000_000 / BAUD_RATE;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping; one-hot plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int            k;
  logic [IW-1:0] kk;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    kk  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k  = (int'(ptr) + i) % NUM_REQ;
      kk = IW'(k);
      if (!any && req[kk]) begin
        any     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx serializer, with stop-bit guard and
// a watchdog that abandons a packet if the serializer never signals completion.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GUARD_CYCLES   = BIT_CYCLES,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_end,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(max2(TIMEOUT_CYCLES, GUARD_CYCLES) + 1);

  tx_state_e          state;
  logic [IW-1:0]      ptr, gidx, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any, last_q, xfer;
  logic [TW-1:0]      timer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign o_req_ready = (state == ST_LOAD) ? o_grant : '0;
  assign o_busy      = (state != ST_IDLE);
  assign xfer        = |(i_req_valid & o_req_ready);

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_grant    <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      gidx       <= '0;
      o_tx_data  <= '0;
      last_q     <= 1'b0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      timer      <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Pointer moves at grant time so an aborted owner still yields priority.
          if (arb_any) begin
            o_grant <= arb_gnt;
            gidx    <= arb_idx;
            ptr     <= arb_idx;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            o_tx_data  <= i_req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
            last_q     <= i_req_last[gidx];
            o_tx_start <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_END;
        end
        ST_WAIT_END: begin
          // End wins over the watchdog when both land in the same cycle.
          if (i_tx_end) begin
            timer <= '0;
            state <= ST_GUARD;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            o_grant   <= '0;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GUARD: begin
          // End pulse precedes the stop bit; hold off the next start until it is out.
          if (timer == TW'(GUARD_CYCLES - 1)) begin
            if (last_q) begin
              o_grant <= '0;
              state   <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, delayed-end serializer model, packet-order model.
module tb_uart_tx_arbiter;

  localparam int N = 4, DW = 8, G = 4, TO = 100, QD = 64, LD = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready, grant;
  logic [DW-1:0]   tx_data;
  logic            tx_start, busy, timeout;
  logic            tx_end = 1'b0;

  int errors = 0, checks = 0, cyc = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk_sys   (clk),
    .i_rst       (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_end    (tx_end),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester byte queues: {last, data}; head advanced only by the driver.
  logic [DW:0] qb [N][QD];
  int          qh [N];
  int          qt [N];
  logic [N-1:0] hold = '0, pend = '0;
  bit          flush = 1'b1;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (flush) qh[k] = qt[k];
      else if (pend[k]) qh[k] = qh[k] + 1;
      req_valid[k]         = !hold[k] && (qh[k] != qt[k]);
      req_data[k*DW +: DW] = qb[k][qh[k] % QD][DW-1:0];
      req_last[k]          = qb[k][qh[k] % QD][DW];
      pend[k]              = req_valid[k] & req_ready[k];
    end
  end

  // Serializer model plus start/timeout logs.
  int          end_dly = 20, stray_cyc = -1, last_start = -1000;
  bit          model_en = 1'b1;
  int          n_st = 0, n_to = 0, to_cyc = 0;
  int          st_cyc [LD];
  logic [DW-1:0] st_data [LD];
  logic [N-1:0]  st_gnt [LD];
  logic [N-1:0]  to_gnt = '0;

  always @(negedge clk) begin
    if (tx_start) begin
      last_start       = cyc;
      st_cyc[n_st%LD]  = cyc;
      st_data[n_st%LD] = tx_data;
      st_gnt[n_st%LD]  = grant;
      n_st             = n_st + 1;
    end
    if (timeout) begin
      to_cyc = cyc;
      to_gnt = grant;
      n_to   = n_to + 1;
    end
    tx_end = (model_en && cyc == last_start + end_dly) || (cyc == stray_cyc);
  end

  // Expected byte stream derived from the queued packets and the round-robin rule.
  logic [DW-1:0] exp_data [LD];
  logic [N-1:0]  exp_gnt [LD];
  bit            exp_first [LD];
  int            tb_ptr = N - 1;

  task automatic model_expect(output int n);
    int cur [N];
    int p, r;
    bit found;
    logic [DW:0] b;
    n = 0;
    p = tb_ptr;
    for (int k = 0; k < N; k++) cur[k] = qh[k];
    forever begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        r = (p + i) % N;
        if (!found && cur[r] != qt[r]) begin found = 1; p = r; end
      end
      if (!found) break;
      exp_first[n] = 1;
      do begin
        b = qb[p][cur[p] % QD];
        exp_data[n] = b[DW-1:0];
        exp_gnt[n]  = N'(1 << p);
        if (b[DW] == 1'b0 || 1) begin end
        n = n + 1;
        cur[p] = cur[p] + 1;
        if (!b[DW] && cur[p] != qt[p]) exp_first[n] = 0;
      end while (!b[DW] && cur[p] != qt[p]);
    end
    tb_ptr = p;
  endtask

  task automatic enq(input int k, input logic [DW-1:0] d, input bit last);
    qb[k][qt[k] % QD] = {last, d};
    qt[k] = qt[k] + 1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1; flush = 1; hold = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0; flush = 0; tb_ptr = N - 1;
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      ok = (n_st >= target);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    bit empty;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      empty = 1;
      for (int k = 0; k < N; k++) if (qh[k] != qt[k] && !hold[k]) empty = 0;
      ok = empty && !busy;
    end
  endtask

  task automatic test_reset;
    rst = 1; flush = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 0; flush = 0; tb_ptr = N - 1;
  endtask

  task automatic test_single;
    int b, x;
    bit ok;
    do_reset();
    end_dly = 20;
    b = n_st;
    x = cyc;
    enq(0, 8'hA5, 0);
    enq(0, 8'h3C, 1);
    wait_idle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got=busy exp=idle"); end
    checks++; if (n_st - b !== 2) begin errors++; $display("FAIL single_count got=%0d exp=2", n_st - b); end
    checks++; if (st_data[b] !== 8'hA5 || st_data[b+1] !== 8'h3C)
      begin errors++; $display("FAIL single_data got=%h,%h exp=a5,3c", st_data[b], st_data[b+1]); end
    checks++; if (st_gnt[b] !== 4'b0001 || st_gnt[b+1] !== 4'b0001)
      begin errors++; $display("FAIL single_grant got=%b,%b exp=0001", st_gnt[b], st_gnt[b+1]); end
    checks++; if (st_cyc[b] - x !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", st_cyc[b] - x); end
    checks++; if (st_cyc[b+1] - (st_cyc[b] + 20) !== G + 2)
      begin errors++; $display("FAIL single_gap got=%0d exp=%0d", st_cyc[b+1] - st_cyc[b] - 20, G + 2); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL single_grant_idle got=%b exp=0000", grant); end
    tb_ptr = 0;
  endtask

  task automatic test_contention;
    int b, n;
    bit ok;
    @(posedge clk); #1;
    rst = 1; flush = 1;
    repeat (2) @(posedge clk);
    #1 flush = 0;
    enq(0, 8'h11, 0); enq(0, 8'h22, 1);
    enq(2, 8'h33, 0); enq(2, 8'h44, 1);
    tb_ptr = N - 1;
    model_expect(n);
    b = n_st;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_idle(1000, ok);
    checks++; if (!ok || n_st - b !== n) begin errors++; $display("FAIL contention_count got=%0d exp=%0d", n_st - b, n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (st_data[b+i] !== exp_data[i] || st_gnt[b+i] !== exp_gnt[i]) begin
        errors++;
        $display("FAIL contention_byte%0d got=%h/%b exp=%h/%b", i, st_data[b+i], st_gnt[b+i], exp_data[i], exp_gnt[i]);
      end
    end
  endtask

  task automatic test_fairness;
    int b;
    bit ok;
    logic [N-1:0] e;
    do_reset();
    end_dly = $urandom_range(3, 30);
    b = n_st;
    for (int i = 0; i < 3; i++) begin
      enq(1, DW'($urandom), 1);
      enq(3, DW'($urandom), 1);
    end
    wait_idle(2000, ok);
    checks++; if (!ok || n_st - b !== 6) begin errors++; $display("FAIL fair_count got=%0d exp=6", n_st - b); end
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (st_gnt[b+i] !== e) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", i, st_gnt[b+i], e); end
    end
    tb_ptr = 3;
  endtask

  task automatic test_random;
    int b, n, d, np, len, tot, eg;
    bit ok;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(2, 40);
      end_dly = d;
      tot = 0;
      for (int k = 0; k < N; k++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) enq(k, DW'($urandom), j == len - 1);
          tot = tot + len;
        end
      end
      if (tot == 0) enq(r % N, DW'($urandom), 1);
      model_expect(n);
      b = n_st;
      wait_idle(5000, ok);
      checks++; if (!ok || n_st - b !== n) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, n_st - b, n); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (st_data[b+i] !== exp_data[i] || st_gnt[b+i] !== exp_gnt[i]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d got=%h/%b exp=%h/%b", r, i, st_data[b+i], st_gnt[b+i], exp_data[i], exp_gnt[i]);
        end
        if (i > 0) begin
          // Within a packet: end, guard, load, start; a new packet adds one arbitration cycle.
          eg = d + G + (exp_first[i] ? 3 : 2);
          checks++;
          if (st_cyc[b+i] - st_cyc[b+i-1] !== eg) begin
            errors++;
            $display("FAIL rand%0d_gap%0d got=%0d exp=%0d", r, i, st_cyc[b+i] - st_cyc[b+i-1], eg);
          end
        end
      end
    end
    end_dly = 20;
  endtask

  task automatic test_timeout;
    int b, bt;
    bit ok;
    do_reset();
    model_en = 0;
    b = n_st;
    bt = n_to;
    enq(1, 8'h77, 0); enq(1, 8'h78, 1);
    enq(2, 8'h55, 1);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(posedge clk); #1; ok = (n_to > bt); end
    model_en = 1;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_seen got=none exp=pulse"); end
    // Timer hits the limit TO cycles after the start pulse; the registered pulse is one later.
    checks++; if (to_cyc - st_cyc[b] !== TO + 1) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", to_cyc - st_cyc[b], TO + 1); end
    checks++; if (to_gnt !== '0) begin errors++; $display("FAIL timeout_grant got=%b exp=0000", to_gnt); end
    wait_idle(1000, ok);
    checks++; if (!ok || n_st - b !== 3) begin errors++; $display("FAIL timeout_count got=%0d exp=3", n_st - b); end
    checks++; if (st_gnt[b+1] !== 4'b0100 || st_data[b+1] !== 8'h55)
      begin errors++; $display("FAIL timeout_next got=%b/%h exp=0100/55", st_gnt[b+1], st_data[b+1]); end
    checks++; if (st_gnt[b+2] !== 4'b0010 || st_data[b+2] !== 8'h78)
      begin errors++; $display("FAIL timeout_remain got=%b/%h exp=0010/78", st_gnt[b+2], st_data[b+2]); end
    checks++; if (n_to - bt !== 1) begin errors++; $display("FAIL timeout_once got=%0d exp=1", n_to - bt); end
    tb_ptr = 1;
  endtask

  task automatic test_stray_end;
    int b, bt;
    bit ok;
    do_reset();
    end_dly = 20;
    b = n_st;
    enq(0, 8'h81, 0);
    wait_starts(b + 1, 100, ok);
    repeat (40) @(posedge clk);
    #1 stray_cyc = cyc + 1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0001 || busy !== 1'b1)
      begin errors++; $display("FAIL stray_load got=%b/%b exp=0001/1", req_ready, busy); end
    checks++; if (n_st - b !== 1) begin errors++; $display("FAIL stray_nostart got=%0d exp=1", n_st - b); end
    enq(0, 8'h82, 1);
    wait_idle(500, ok);
    checks++; if (!ok || n_st - b !== 2 || st_data[b+1] !== 8'h82 || st_gnt[b+1] !== 4'b0001)
      begin errors++; $display("FAIL stray_resume got=%0d/%h exp=2/82", n_st - b, st_data[b+1]); end
    end_dly = TO;
    b = n_st;
    bt = n_to;
    enq(1, 8'h90, 1);
    wait_idle(500, ok);
    checks++; if (n_to !== bt) begin errors++; $display("FAIL edge_timeout got=%0d exp=0", n_to - bt); end
    checks++; if (!ok || n_st - b !== 1 || st_gnt[b] !== 4'b0010)
      begin errors++; $display("FAIL edge_done got=%0d/%b exp=1/0010", n_st - b, st_gnt[b]); end
    end_dly = 20;
    tb_ptr = 1;
  endtask

  task automatic test_reset_mid;
    int b;
    bit ok;
    do_reset();
    b = n_st;
    enq(1, 8'hC1, 1);
    wait_starts(b + 1, 100, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || grant !== 4'b0010)
      begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/0010", busy, grant); end
    rst = 1; flush = 1;
    #1;
    checks++; if (grant !== '0 || req_ready !== '0 || tx_data !== '0 || tx_start !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0)
      begin errors++; $display("FAIL mid_reset got=%b/%b/%h/%b/%b/%b exp=all zero", grant, req_ready, tx_data, tx_start, busy, timeout); end
    repeat (3) @(posedge clk);
    #1 rst = 0; flush = 0; tb_ptr = N - 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (n_st - b !== 1) begin errors++; $display("FAIL mid_nostart got=%0d exp=1", n_st - b); end
    enq(1, 8'hD1, 1);
    enq(0, 8'hD0, 1);
    wait_idle(500, ok);
    checks++; if (!ok || n_st - b !== 3 || st_gnt[b+1] !== 4'b0001 || st_data[b+1] !== 8'hD0)
      begin errors++; $display("FAIL mid_first got=%b/%h exp=0001/d0", st_gnt[b+1], st_data[b+1]); end
    checks++; if (st_gnt[b+2] !== 4'b0010 || st_data[b+2] !== 8'hD1)
      begin errors++; $display("FAIL mid_second got=%b/%h exp=0010/d1", st_gnt[b+2], st_data[b+2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_timeout();
    test_stray_end();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
